display_scan_ring: RTL



---
 rtl/display_scan_ring.sv | 139 +++++++++++++
 1 files changed

// File: rtl/display_scan_ring.sv
// display_scan_ring
// Multiplexed 7-segment display scanner. A prescaler divides the system clock
// into digit slots of DIV cycles. At each slot end the select advances to the
// next digit whose mask bit is set. The first BLANK cycles of every slot keep
// all anodes off to avoid ghosting while the segment mux settles.
//
// Ports
//   i_Clk    system clock, rising edge
//   i_Rst    synchronous active-high reset
//   i_En     scan enable; low freezes the scan and blanks the display
//   i_Mask   per-digit enable, bit k = digit k shown
//   o_Anodo  one-hot anode drive, polarity set by ANODE_ACTIVE_LOW
//   o_Sel    index of the current digit, for the segment mux
//   o_Tick   one-cycle pulse at every slot end
//   o_Frame  one-cycle pulse when the scan wraps (new sel <= old sel)
module display_scan_ring #(
    parameter int unsigned N_DIGITS         = 4,
    parameter int unsigned SEL_W            = 2,
    parameter int unsigned DIV              = 50000,
    parameter int unsigned BLANK            = 2,
    parameter int unsigned ANODE_ACTIVE_LOW = 0
) (
    input  logic                i_Clk,
    input  logic                i_Rst,
    input  logic                i_En,
    input  logic [N_DIGITS-1:0] i_Mask,
    output logic [N_DIGITS-1:0] o_Anodo,
    output logic [SEL_W-1:0]    o_Sel,
    output logic                o_Tick,
    output logic                o_Frame
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    // Inactive anode level, replicated across the vector.
    localparam logic [N_DIGITS-1:0] ANODE_OFF = {N_DIGITS{(ANODE_ACTIVE_LOW != 0)}};

    // State and registered outputs
    logic [CNT_W-1:0]    r_cnt;
    logic [SEL_W-1:0]    r_sel;
    logic [N_DIGITS-1:0] r_anodo;
    logic                r_tick;
    logic                r_frame;

    // Next-state values
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [SEL_W-1:0]    w_sel_nxt;
    logic [N_DIGITS-1:0] w_anodo_nxt;
    logic                w_tick_nxt;
    logic                w_frame_nxt;

    // Advance search results
    logic                w_found;
    logic [SEL_W-1:0]    w_next_sel;

    logic                w_slot_end;
    logic [N_DIGITS-1:0] w_onehot_nxt;
    logic                w_mask_bit_nxt;

    // Rotating search: first enabled digit after r_sel, ending at r_sel itself.
    always_comb begin
        int unsigned v_idx;
        v_idx      = 0;
        w_found    = 1'b0;
        w_next_sel = r_sel;
        for (int unsigned k = 1; k <= N_DIGITS; k++) begin
            v_idx = 32'(r_sel) + k;
            if (v_idx >= N_DIGITS) begin
                v_idx = v_idx - N_DIGITS;
            end
            if (!w_found && (|(i_Mask & (N_DIGITS'(1) << v_idx)))) begin
                w_found    = 1'b1;
                w_next_sel = SEL_W'(v_idx);
            end
        end
    end

    // One-hot of the next select; mask bit taken by AND to stay width-clean
    // when SEL_W is wider than the digit index.
    assign w_onehot_nxt   = N_DIGITS'(1) << w_sel_nxt;
    assign w_mask_bit_nxt = |(i_Mask & w_onehot_nxt);
    assign w_slot_end     = (r_cnt == CNT_LAST);

    // Next-state and output decode
    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_sel_nxt   = r_sel;
        w_tick_nxt  = 1'b0;
        w_frame_nxt = 1'b0;
        w_anodo_nxt = ANODE_OFF;

        if (i_En) begin
            if (w_slot_end) begin
                w_cnt_nxt  = '0;
                w_tick_nxt = 1'b1;
                // An all-zero mask finds nothing: select holds and no frame.
                if (w_found) begin
                    w_sel_nxt   = w_next_sel;
                    w_frame_nxt = (w_next_sel <= r_sel);
                end
            end else begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end

            // Anode lights only after the blanking window and while the
            // digit is still enabled; the mask is applied every cycle.
            if ((32'(w_cnt_nxt) >= BLANK) && w_mask_bit_nxt) begin
                w_anodo_nxt = ANODE_OFF ^ w_onehot_nxt;
            end
        end
    end

    // State register
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_cnt   <= '0;
            r_sel   <= '0;
            r_anodo <= ANODE_OFF;
            r_tick  <= 1'b0;
            r_frame <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_sel   <= w_sel_nxt;
            r_anodo <= w_anodo_nxt;
            r_tick  <= w_tick_nxt;
            r_frame <= w_frame_nxt;
        end
    end

    // Select and anode update on the same edge, so segment data is stable
    // whenever an anode turns on (every slot opens with a blank or the same
    // digit).
    assign o_Anodo = r_anodo;
    assign o_Sel   = r_sel;
    assign o_Tick  = r_tick;
    assign o_Frame = r_frame;

endmodule
